// File: rtl/riscv_defines.sv
// Shared definitions for the FENCE.I sequencing logic.
//   fencei_state_t : controller states (WB only reachable with FENCEI_DCACHE_WB_EN)
//   FENCEI_PC_STEP : distance from the FENCE.I to the instruction fetched after it
package riscv_defines;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    WB       = 3'd2,
    INVAL    = 3'd3,
    REDIRECT = 3'd4
  } fencei_state_t;

  localparam logic [31:0] FENCEI_PC_STEP = 32'd4;

endpackage

// File: rtl/fencei_inval_walker.sv
// Walks every I-cache line index through a valid/ready invalidate handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a walk at index 0 (valid rises the next cycle)
//   ready      : I-cache accepts the current invalidate
//   valid      : invalidate request, held until the last line is accepted
//   idx        : line index, stable while valid && !ready
//   last_done  : handshake of the final line happens this cycle
module fencei_inval_walker
  import riscv_defines::*;
#(
  parameter int unsigned ICACHE_LINES = 64,
  parameter int unsigned IDX_W        = $clog2(ICACHE_LINES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ready,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic             last_done
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(ICACHE_LINES - 1);

  logic             r_active;
  logic [IDX_W-1:0] r_idx;
  logic             w_hs;

  assign w_hs = r_active & ready;

  // The index wraps naturally to 0 after the last line (power-of-two line count).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_idx    <= '0;
    end else if (start) begin
      r_active <= 1'b1;
      r_idx    <= '0;
    end else if (w_hs) begin
      r_idx <= r_idx + 1'b1;
      if (r_idx == LastIdx) begin
        r_active <= 1'b0;
      end
    end
  end

  assign valid     = r_active;
  assign idx       = r_idx;
  assign last_done = w_hs & (r_idx == LastIdx);

endmodule

// File: rtl/fencei_controller.sv
// FENCE.I side-effect sequencer: drains the store buffer, optionally writes back
// the D-cache, invalidates every I-cache line, then redirects fetch to pc + 4.
// Optional feature macro: FENCEI_DCACHE_WB_EN (adds the WB state).
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   fencei_valid, fencei_pc        : FENCE.I request pulse and its PC
//   kill                           : flush, honoured only in DRAIN and WB
//   sb_empty                       : store buffer is empty
//   dc_wb_req / dc_wb_done         : D-cache writeback request / completion pulse
//   ic_inv_valid/idx/ready         : I-cache invalidate handshake
//   stall, busy                    : pipeline hold, controller active
//   redirect_valid, redirect_pc    : one-cycle fetch redirect
module fencei_controller
  import riscv_defines::*;
#(
  parameter int unsigned ICACHE_LINES = 64,
  parameter int unsigned IDX_W        = $clog2(ICACHE_LINES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fencei_valid,
  input  logic [31:0]      fencei_pc,
  input  logic             kill,
  input  logic             sb_empty,
  output logic             dc_wb_req,
  input  logic             dc_wb_done,
  output logic             ic_inv_valid,
  output logic [IDX_W-1:0] ic_inv_idx,
  input  logic             ic_inv_ready,
  output logic             stall,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             busy
);

  fencei_state_t    r_state;
  fencei_state_t    w_state_d;
  logic [31:0]      r_pc;
  logic             w_accept;
  logic             w_start;
  logic             w_last_done;
  logic             w_inv_valid;
  logic [IDX_W-1:0] w_inv_idx;

`ifndef FENCEI_DCACHE_WB_EN
  logic w_unused_dc_wb_done;
  assign w_unused_dc_wb_done = dc_wb_done;
`endif

  assign w_accept = (r_state == IDLE) & fencei_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_pc <= fencei_pc;
      end
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_start        = 1'b0;
    stall          = w_accept | (r_state != IDLE);
    busy           = (r_state != IDLE);
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dc_wb_req      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (fencei_valid) w_state_d = DRAIN;
      end
      DRAIN: begin
        if (kill) begin
          w_state_d = IDLE;
        end else if (sb_empty) begin
`ifdef FENCEI_DCACHE_WB_EN
          w_state_d = WB;
`else
          w_state_d = INVAL;
          w_start   = 1'b1;
`endif
        end
      end
      WB: begin
`ifdef FENCEI_DCACHE_WB_EN
        dc_wb_req = 1'b1;
        if (kill) begin
          w_state_d = IDLE;
        end else if (dc_wb_done) begin
          w_state_d = INVAL;
          w_start   = 1'b1;
        end
`else
        w_state_d = IDLE;
`endif
      end
      INVAL: begin
        if (w_last_done) w_state_d = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = r_pc + FENCEI_PC_STEP;
        w_state_d      = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  fencei_inval_walker #(
    .ICACHE_LINES(ICACHE_LINES),
    .IDX_W       (IDX_W)
  ) u_walker (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_start),
    .ready    (ic_inv_ready),
    .valid    (w_inv_valid),
    .idx      (w_inv_idx),
    .last_done(w_last_done)
  );

  assign ic_inv_valid = w_inv_valid;
  assign ic_inv_idx   = w_inv_idx;

endmodule

// File: tb/tb_fencei_controller.sv
// Self-checking bench for fencei_controller (4-line I-cache), with a progress-based
// reference model and directed literal checks. Honours FENCEI_DCACHE_WB_EN.
module tb_fencei_controller;

  localparam int N  = 4;
  localparam int IW = $clog2(N);
`ifdef FENCEI_DCACHE_WB_EN
  localparam bit WbEn = 1'b1;
`else
  localparam bit WbEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fencei_valid;
  logic [31:0]   fencei_pc;
  logic          kill;
  logic          sb_empty;
  logic          dc_wb_req;
  logic          dc_wb_done;
  logic          ic_inv_valid;
  logic [IW-1:0] ic_inv_idx;
  logic          ic_inv_ready;
  logic          stall;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          busy;

  fencei_controller #(
    .ICACHE_LINES(N)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fencei_valid  (fencei_valid),
    .fencei_pc     (fencei_pc),
    .kill          (kill),
    .sb_empty      (sb_empty),
    .dc_wb_req     (dc_wb_req),
    .dc_wb_done    (dc_wb_done),
    .ic_inv_valid  (ic_inv_valid),
    .ic_inv_idx    (ic_inv_idx),
    .ic_inv_ready  (ic_inv_ready),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: tracks progress milestones of the current fence rather than a state.
  bit          m_active  = 1'b0;
  bit          m_drained = 1'b0;
  bit          m_wbdone  = 1'b0;
  int          m_inv     = 0;
  logic [31:0] m_pc      = '0;

  // Outputs sampled at the most recent falling edge.
  logic          s_stall, s_busy, s_iv, s_rv, s_wb;
  logic [IW-1:0] s_idx;
  logic [31:0]   s_rpc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: sample and compare at negedge, advance model, return at posedge+1.
  task automatic tick();
    bit e_inval, e_redir;
    @(negedge clk);
    s_stall = stall; s_busy = busy; s_iv = ic_inv_valid; s_rv = redirect_valid;
    s_wb = dc_wb_req; s_idx = ic_inv_idx; s_rpc = redirect_pc;
    if (!rst_n) begin
      m_active = 1'b0; m_drained = 1'b0; m_wbdone = 1'b0; m_inv = 0; m_pc = '0;
    end else begin
      e_inval = m_active && m_drained && m_wbdone && (m_inv < N);
      e_redir = m_active && (m_inv == N);
      check("stall", 32'(s_stall), 32'(m_active || fencei_valid));
      check("busy", 32'(s_busy), 32'(m_active));
      check("ic_inv_valid", 32'(s_iv), 32'(e_inval));
      check("ic_inv_idx", 32'(s_idx), 32'(m_inv % N));
      check("dc_wb_req", 32'(s_wb), 32'(WbEn && m_active && m_drained && !m_wbdone));
      check("redirect_valid", 32'(s_rv), 32'(e_redir));
      check("redirect_pc", s_rpc, e_redir ? m_pc + 32'd4 : 32'd0);
      if (!m_active) begin
        if (fencei_valid) begin
          m_active = 1'b1; m_pc = fencei_pc; m_drained = 1'b0;
          m_wbdone = !WbEn; m_inv = 0;
        end
      end else if (e_redir) begin
        m_active = 1'b0; m_inv = 0;
      end else if (!m_drained) begin
        if (kill) m_active = 1'b0;
        else if (sb_empty) m_drained = 1'b1;
      end else if (!m_wbdone) begin
        if (kill) m_active = 1'b0;
        else if (dc_wb_done) m_wbdone = 1'b1;
      end else if (ic_inv_ready) begin
        m_inv++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic finish_op();
    int b;
    fencei_valid = 1'b0; kill = 1'b0; sb_empty = 1'b1; ic_inv_ready = 1'b1; dc_wb_done = 1'b1;
    b = 0;
    do begin
      tick();
      b++;
    end while (s_busy && b < 60);
    check("op_completes", 32'(s_busy), 32'd0);
    dc_wb_done = 1'b0;
  endtask

  initial begin
    int          stall_cnt, hs, seen_rv, b;
    int          hs_idx[$];
    logic        prev_iv, prev_rdy;
    logic [IW-1:0] prev_idx;

    rst_n = 1'b0; fencei_valid = 1'b0; fencei_pc = '0; kill = 1'b0; sb_empty = 1'b0;
    dc_wb_done = 1'b0; ic_inv_ready = 1'b0;
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_iv", 32'(ic_inv_valid), 32'd0);
    check("rst_idx", 32'(ic_inv_idx), 32'd0);
    check("rst_rv", 32'(redirect_valid), 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
    check("rst_wb", 32'(dc_wb_req), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();

`ifndef FENCEI_DCACHE_WB_EN
    // Best-case fence at pc 0x1000.
    sb_empty = 1'b1; ic_inv_ready = 1'b1; fencei_pc = 32'h0000_1000; fencei_valid = 1'b1;
    tick();
    check("d1_accept_stall", 32'(s_stall), 32'd1);
    stall_cnt = int'(s_stall);
    fencei_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      stall_cnt += int'(s_stall);
      if (c >= 2 && c <= 5) begin
        check("d1_inv_valid", 32'(s_iv), 32'd1);
        check("d1_idx", 32'(s_idx), 32'(c - 2));
      end else begin
        check("d1_inv_valid_off", 32'(s_iv), 32'd0);
      end
      check("d1_redirect_valid", 32'(s_rv), 32'(c == 6));
      if (c == 6) check("d1_redirect_pc", s_rpc, 32'h0000_1004);
    end
    check("d1_stall_cycles", 32'(stall_cnt), 32'd7);
`else
    // Writeback: req from cycle 2 until done, INVAL the following cycle.
    sb_empty = 1'b1; ic_inv_ready = 1'b1; dc_wb_done = 1'b0; fencei_pc = 32'h0000_2000;
    fencei_valid = 1'b1;
    tick();
    fencei_valid = 1'b0;
    tick();
    check("wb_c1_req", 32'(s_wb), 32'd0);
    tick();
    check("wb_c2_req", 32'(s_wb), 32'd1);
    tick();
    check("wb_c3_req", 32'(s_wb), 32'd1);
    dc_wb_done = 1'b1;
    tick();
    check("wb_c4_req", 32'(s_wb), 32'd1);
    check("wb_c4_iv", 32'(s_iv), 32'd0);
    dc_wb_done = 1'b0;
    tick();
    check("wb_c5_req", 32'(s_wb), 32'd0);
    check("wb_c5_iv", 32'(s_iv), 32'd1);
    check("wb_c5_idx", 32'(s_idx), 32'd0);
    finish_op();
`endif

    // pc wrap.
    sb_empty = 1'b1; ic_inv_ready = 1'b1; dc_wb_done = 1'b1;
    fencei_pc = 32'hFFFF_FFFC; fencei_valid = 1'b1;
    tick();
    fencei_valid = 1'b0;
    b = 0;
    do begin tick(); b++; end while (!s_rv && b < 30);
    check("wrap_redirect_seen", 32'(s_rv), 32'd1);
    check("wrap_redirect_pc", s_rpc, 32'h0000_0000);
    finish_op();

    // Store buffer busy for 5 cycles after accept.
    sb_empty = 1'b0; dc_wb_done = 1'b1; fencei_pc = 32'h0000_3000; fencei_valid = 1'b1;
    tick();
    fencei_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check("sb_stall", 32'(s_stall), 32'd1);
      check("sb_no_inv", 32'(s_iv), 32'd0);
    end
    sb_empty = 1'b1;
    tick();
    check("sb_rise_no_inv", 32'(s_iv), 32'd0);
`ifndef FENCEI_DCACHE_WB_EN
    tick();
    check("sb_inv_next", 32'(s_iv), 32'd1);
`endif
    finish_op();

    // ready toggling 1,0,0,...: idx stable while stalled, four distinct handshakes.
    sb_empty = 1'b1; dc_wb_done = 1'b1; fencei_pc = 32'h0000_4000; fencei_valid = 1'b1;
    tick();
    fencei_valid = 1'b0;
    hs_idx.delete();
    prev_iv = 1'b0; prev_rdy = 1'b1; prev_idx = '0;
    for (int k = 0; k < 30; k++) begin
      ic_inv_ready = ((k % 3) == 0);
      tick();
      if (s_iv && prev_iv && !prev_rdy) check("rdy_idx_stable", 32'(s_idx), 32'(prev_idx));
      if (s_iv && ic_inv_ready) hs_idx.push_back(int'(s_idx));
      prev_iv = s_iv; prev_rdy = ic_inv_ready; prev_idx = s_idx;
    end
    check("rdy_handshakes", 32'(hs_idx.size()), 32'd4);
    for (int i = 0; i < hs_idx.size(); i++) check("rdy_hs_order", 32'(hs_idx[i]), 32'(i));
    finish_op();

    // kill in DRAIN.
    sb_empty = 1'b0; fencei_valid = 1'b1; fencei_pc = 32'h0000_5000;
    tick();
    fencei_valid = 1'b0; kill = 1'b1;
    tick();
    kill = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("kdr_busy", 32'(s_busy), 32'd0);
      check("kdr_iv", 32'(s_iv), 32'd0);
      check("kdr_rv", 32'(s_rv), 32'd0);
    end

    // kill in INVAL is ignored.
    sb_empty = 1'b1; ic_inv_ready = 1'b1; dc_wb_done = 1'b1; fencei_pc = 32'h0000_6000;
    fencei_valid = 1'b1;
    tick();
    fencei_valid = 1'b0;
    hs = 0; seen_rv = 0; b = 0;
    do begin
      tick();
      if (s_iv) begin
        kill = 1'b1;
        if (ic_inv_ready) hs++;
      end
      if (s_rv) seen_rv = 1;
      b++;
    end while (!s_rv && b < 30);
    kill = 1'b0;
    check("kinv_handshakes", 32'(hs), 32'd4);
    check("kinv_redirect", 32'(seen_rv), 32'd1);
    check("kinv_redirect_pc", s_rpc, 32'h0000_6004);
    finish_op();

    // Asynchronous reset in INVAL at idx 2.
    sb_empty = 1'b1; ic_inv_ready = 1'b1; dc_wb_done = 1'b1; fencei_pc = 32'h0000_7000;
    fencei_valid = 1'b1;
    tick();
    fencei_valid = 1'b0;
    b = 0;
    do begin tick(); b++; end while (!(s_iv && s_idx == IW'(1)) && b < 20);
    check("rstm_reach_idx1", 32'(s_idx), 32'd1);
    ic_inv_ready = 1'b0;
    #1;
    check("rstm_pre_idx", 32'(ic_inv_idx), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstm_stall", 32'(stall), 32'd0);
    check("rstm_busy", 32'(busy), 32'd0);
    check("rstm_iv", 32'(ic_inv_valid), 32'd0);
    check("rstm_idx", 32'(ic_inv_idx), 32'd0);
    check("rstm_rv", 32'(redirect_valid), 32'd0);
    check("rstm_wb", 32'(dc_wb_req), 32'd0);
    tick();
    rst_n = 1'b1;
    ic_inv_ready = 1'b1; fencei_pc = 32'h0000_8000; fencei_valid = 1'b1;
    tick();
    fencei_valid = 1'b0;
    b = 0;
    do begin tick(); b++; end while (!s_iv && b < 10);
    check("rstm_restart_iv", 32'(s_iv), 32'd1);
    check("rstm_restart_idx0", 32'(s_idx), 32'd0);
    finish_op();

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      fencei_valid = ($urandom_range(0, 7) == 0);
      fencei_pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      sb_empty     = ($urandom_range(0, 2) != 0);
      kill         = ($urandom_range(0, 15) == 0);
      ic_inv_ready = ($urandom_range(0, 2) != 0);
      dc_wb_done   = ($urandom_range(0, 3) == 0);
      tick();
    end
    finish_op();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
